// File: rtl/aes_128_iter.sv
// aes_128_iter: iterative FIPS-197 AES-128 encryptor with on-the-fly key expansion.
// ROUNDS_PER_CYCLE rounds (1, 2, 5 or 10) are unrolled into one combinational datapath
// that is reused every clock. A user tag of TAG_W bits travels with each block.
// Optional build macro AES_ITER_ZEROIZE_EN: clears state/round-key registers once the
// result is captured, and clears out/out_tag after the output handshake.
// Byte 0 of a block is bits [127:120]; column c holds bytes 4c..4c+3.
module aes_128_iter #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int TAG_W            = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     state,
    input  logic [127:0]     key,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
        $error("aes_128_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    localparam logic [3:0] RPC4 = 4'(ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // ---------------------------------------------------------------
    // GF(2^8) and AES primitive functions
    // ---------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // S-box computed as multiplicative inverse (x^254, which maps 0 to 0) followed by
    // the affine transform, rather than a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]), mix_column(s[31:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // The final round omits MixColumns.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        t = shift_rows(sub_bytes(s));
        if (!last) t = mix_columns(t);
        return t ^ rk;
    endfunction

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    fsm_t             fsm_q, fsm_d;
    logic [127:0]     s_q, s_d;
    logic [127:0]     k_q, k_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [127:0]     out_q, out_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             accept;
    logic [3:0]       cnt_nxt;
    logic [127:0]     s_run;
    logic [127:0]     k_run;

    assign cnt_nxt   = cnt_q + RPC4;
    assign busy      = (fsm_q == RUN);
    assign out_valid = (fsm_q == DONE);
    assign out       = out_q;
    assign out_tag   = out_tag_q;

    // Unrolled datapath: ROUNDS_PER_CYCLE consecutive rounds starting after cnt_q.
    always_comb begin
        logic [3:0] idx;
        s_run = s_q;
        k_run = k_q;
        idx   = cnt_q;
        for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            idx   = cnt_q + 4'(r + 1);
            k_run = next_key(k_run, rcon(idx));
            s_run = aes_round(s_run, k_run, idx == 4'd10);
        end
    end

    // FSM next state, in_ready and the accept strobe.
    always_comb begin
        fsm_d    = fsm_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) fsm_d = RUN;
            end
            RUN: begin
                if (cnt_nxt == 4'd10) fsm_d = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    accept = in_valid;
                    fsm_d  = in_valid ? RUN : IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Datapath next state: load on accept, iterate in RUN, capture result on the last step.
    always_comb begin
        s_d       = s_q;
        k_d       = k_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        out_tag_d = out_tag_q;
        if (accept) begin
            s_d   = state ^ key;
            k_d   = key;
            tag_d = in_tag;
            cnt_d = 4'd0;
        end else if (fsm_q == RUN) begin
            s_d   = s_run;
            k_d   = k_run;
            cnt_d = cnt_nxt;
            if (cnt_nxt == 4'd10) begin
                out_d     = s_run;
                out_tag_d = tag_q;
`ifdef AES_ITER_ZEROIZE_EN
                s_d       = '0;
                k_d       = '0;
`endif
            end
        end
`ifdef AES_ITER_ZEROIZE_EN
        if (fsm_q == DONE && out_ready && !accept) begin
            out_d     = '0;
            out_tag_d = '0;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    // Datapath registers; reset clears everything so an aborted block leaves no residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            k_q       <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            out_tag_q <= '0;
        end else begin
            s_q       <= s_d;
            k_q       <= k_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            out_tag_q <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_aes_128_iter.sv
// Bench for aes_128_iter: four instances (1, 2, 5, 10 rounds per cycle) share one input bus;
// instance 0 is the main device, the others are checked for C.1 latency/result.
module tb_aes_128_iter;

    localparam int NI = 4;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] st_in;
    logic [127:0] key_in;
    logic [3:0]   tag_in;
    logic         out_ready;

    logic         in_ready_w  [NI];
    logic         out_valid_w [NI];
    logic [127:0] out_w       [NI];
    logic [3:0]   out_tag_w   [NI];
    logic         busy_w      [NI];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    function automatic int rpc_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_128_iter #(.ROUNDS_PER_CYCLE(rpc_of(g)), .TAG_W(4)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .state     (st_in),
            .key       (key_in),
            .in_tag    (tag_in),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out       (out_w[g]),
            .out_tag   (out_tag_w[g]),
            .busy      (busy_w[g])
        );
    end

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        logic [7:0] y;
        r = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) r ^= x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return r;
    endfunction

    // S-box generated by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] v [4];
        logic [7:0] rc;
        logic [7:0] u;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) v[j] = w[i-4+j];
            if (i % 16 == 0) begin
                u = v[0];
                v[0] = sb[v[1]] ^ rc;
                v[1] = sb[v[2]];
                v[2] = sb[v[3]];
                v[3] = sb[u];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ v[j];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c]   = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
                    s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] k, input logic [127:0] pt, input logic [3:0] tg);
        int n;
        key_in = k; st_in = pt; tag_in = tg; in_valid = 1'b1;
        n = 0;
        while (!in_ready_w[0] && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("send");
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid_w[0] && lat < 40) begin tick(); lat++; end
        if (lat >= 40) timeout("wait_out");
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] k, input logic [127:0] pt, input logic [3:0] tg,
                             output logic [127:0] ct, output logic [3:0] otg, output int lat);
        send(k, pt, tg);
        wait_out(lat);
        ct  = out_w[0];
        otg = out_tag_w[0];
        handshake();
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [3:0]   tag;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct, rk, rp;
        logic [3:0]   otg, rt;
        int           lat;
        int           lats [NI];
        logic [127:0] outs [NI];
        logic         seen;

        vecs[0] = '{key: C1_KEY, pt: C1_PT, tag: 4'h1, ct: C1_CT};
        vecs[1] = '{key: 128'h0, pt: 128'h0, tag: 4'hA, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[2] = '{key: B_KEY, pt: B_PT, tag: 4'h6, ct: B_CT};

        build_sbox();
        rst = 1'b1; in_valid = 1'b0; st_in = '0; key_in = '0; tag_in = '0; out_ready = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_out_valid", 128'(out_valid_w[0]), 128'd0);
        chk("rst_busy", 128'(busy_w[0]), 128'd0);
        chk("rst_out", out_w[0], 128'd0);
        chk("rst_out_tag", 128'(out_tag_w[0]), 128'd0);
        rst = 1'b0;
        chk("rel_in_ready", 128'(in_ready_w[0]), 128'd1);

        // C.1 latency on every configuration
        key_in = C1_KEY; st_in = C1_PT; tag_in = 4'h2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int g = 0; g < NI; g++) lats[g] = -1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            for (int g = 0; g < NI; g++)
                if (lats[g] < 0 && out_valid_w[g]) begin lats[g] = e; outs[g] = out_w[g]; end
        end
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("c1_latency_rpc%0d", rpc_of(g)), 128'(lats[g]), 128'(10 / rpc_of(g)));
            chk($sformatf("c1_out_rpc%0d", rpc_of(g)), outs[g], C1_CT);
        end
        handshake();

        // table-driven known-answer vectors
        for (int i = 0; i < 3; i++) begin
            run_block(vecs[i].key, vecs[i].pt, vecs[i].tag, ct, otg, lat);
            chk($sformatf("vec%0d_out", i), ct, vecs[i].ct);
            chk($sformatf("vec%0d_tag", i), 128'(otg), 128'(vecs[i].tag));
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd10);
        end

        // random blocks against the model, with in_valid and data churning during RUN
        for (int i = 0; i < 8; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            rt = 4'($urandom);
            send(rk, rp, rt);
            chk("rand_busy", 128'(busy_w[0]), 128'd1);
            chk("rand_in_ready_run", 128'(in_ready_w[0]), 128'd0);
            lat = 0;
            while (!out_valid_w[0] && lat < 40) begin
                in_valid = 1'($urandom);
                st_in    = {$urandom, $urandom, $urandom, $urandom};
                key_in   = {$urandom, $urandom, $urandom, $urandom};
                tag_in   = 4'($urandom);
                tick();
                lat++;
            end
            in_valid = 1'b0;
            if (lat >= 40) timeout("rand_wait");
            chk($sformatf("rand%0d_out", i), out_w[0], aes_ref(rk, rp));
            chk($sformatf("rand%0d_tag", i), 128'(out_tag_w[0]), 128'(rt));
            handshake();
        end

        // stall in DONE for 20 cycles, then back-to-back accept on the handshake edge
        send(C1_KEY, C1_PT, 4'h5);
        wait_out(lat);
        for (int c = 0; c < 20; c++) begin
            chk("stall_out", out_w[0], C1_CT);
            chk("stall_tag", 128'(out_tag_w[0]), 128'h5);
            chk("stall_in_ready", 128'(in_ready_w[0]), 128'd0);
            chk("stall_out_valid", 128'(out_valid_w[0]), 128'd1);
            tick();
        end
        key_in = B_KEY; st_in = B_PT; tag_in = 4'h3; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 128'(in_ready_w[0]), 128'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_out_valid_low", 128'(out_valid_w[0]), 128'd0);
        chk("b2b_busy", 128'(busy_w[0]), 128'd1);
        wait_out(lat);
        chk("b2b_latency", 128'(lat), 128'd10);
        chk("b2b_out", out_w[0], B_CT);
        chk("b2b_tag", 128'(out_tag_w[0]), 128'h3);
        handshake();

        // reset aborts a block at round counter 5
        send(C1_KEY, C1_PT, 4'h9);
        for (int c = 0; c < 5; c++) tick();
        chk("abort_busy_before", 128'(busy_w[0]), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", 128'(out_valid_w[0]), 128'd0);
        chk("abort_busy", 128'(busy_w[0]), 128'd0);
        chk("abort_out", out_w[0], 128'd0);
        chk("abort_out_tag", 128'(out_tag_w[0]), 128'd0);
        chk("abort_in_ready", 128'(in_ready_w[0]), 128'd1);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid_w[0]) seen = 1'b1;
        end
        chk("abort_no_output", 128'(seen), 128'd0);
        run_block(C1_KEY, C1_PT, 4'h7, ct, otg, lat);
        chk("after_abort_out", ct, C1_CT);
        chk("after_abort_latency", 128'(lat), 128'd10);

        // output after a handshake with no new block
`ifdef AES_ITER_ZEROIZE_EN
        chk("post_hs_out", out_w[0], 128'd0);
        chk("post_hs_tag", 128'(out_tag_w[0]), 128'd0);
`else
        chk("post_hs_out", out_w[0], C1_CT);
        chk("post_hs_tag", 128'(out_tag_w[0]), 128'h7);
`endif
        chk("post_hs_out_valid", 128'(out_valid_w[0]), 128'd0);
        chk("post_hs_in_ready", 128'(in_ready_w[0]), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
